mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_arb_if.sv | 27 ++
 rtl/mult_share_arb.sv | 116 +++++++++++
 tb/tb_mult_share_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_if.sv
// Handshake bundle between NREQ requesters, the shared multiplier and its result consumer.
interface mult_share_arb_if #(
  parameter int NREQ  = 4,
  parameter int BITS  = 17,
  parameter int WBITS = 17,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*BITS-1:0]  req_data;
  logic [NREQ*WBITS-1:0] req_weight;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [BITS+WBITS-1:0] res_data;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_weight, res_ready,
    input  req_ready, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req_valid, req_data, req_weight, res_ready,
    output req_ready, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mult_share_arb.sv
// One signed multiplier shared by NREQ requesters through a 2-stage elastic pipeline.
// Define MSA_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module mult_share_arb #(
  parameter int NREQ  = 4,
  parameter int BITS  = 17,
  parameter int WBITS = 17,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  mult_share_arb_if.slave  bus
);
  localparam int PW = BITS + WBITS;

  function automatic logic signed [PW-1:0] mul_full(
    input logic signed [BITS-1:0]  a,
    input logic signed [WBITS-1:0] b
  );
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{WBITS{a[BITS-1]}}, a};
    be = {{BITS{b[WBITS-1]}}, b};
    return ae * be;
  endfunction

  logic                    en;
  logic                    xfer;
  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          gidx;
  logic                    found;

  logic                    vld_p1;
  logic signed [BITS-1:0]  data_p1;
  logic signed [WBITS-1:0] weight_p1;
  logic [IDW-1:0]          id_p1;

  logic                    vld_p2;
  logic [IDW-1:0]          id_p2;
  logic signed [PW-1:0]    prod_p2;

  assign en   = !vld_p2 || bus.res_ready;
  assign xfer = en && !reset && (grant != '0);

`ifdef MSA_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;
  int             j;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req_valid[j]) begin
        grant[j] = 1'b1;
        gidx     = IDW'(j);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (xfer) ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
  end
`else
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[k]) begin
        grant[k] = 1'b1;
        gidx     = IDW'(k);
        found    = 1'b1;
      end
    end
  end
`endif

  assign bus.req_ready = xfer ? grant : '0;

  // Stage 1: capture the granted operand pair
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else if (en) vld_p1 <= xfer;
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      data_p1   <= bus.req_data[gidx*BITS +: BITS];
      weight_p1 <= bus.req_weight[gidx*WBITS +: WBITS];
      id_p1     <= gidx;
    end
  end

  // Stage 2: result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      id_p2   <= '0;
      prod_p2 <= '0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      id_p2   <= id_p1;
      prod_p2 <= mul_full(data_p1, weight_p1);
    end
  end

  assign bus.res_valid = vld_p2;
  assign bus.res_id    = id_p2;
  assign bus.res_data  = prod_p2;
  assign bus.busy      = vld_p1 || vld_p2;
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a transfer-order scoreboard; honours MSA_ROUND_ROBIN_EN.
module tb_mult_share_arb;
  localparam int NREQ  = 4;
  localparam int BITS  = 17;
  localparam int WBITS = 17;
  localparam int IDW   = 2;
  localparam int PW    = BITS + WBITS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_share_arb_if #(.NREQ(NREQ), .BITS(BITS), .WBITS(WBITS), .IDW(IDW)) bus();

  mult_share_arb #(.NREQ(NREQ), .BITS(BITS), .WBITS(WBITS), .IDW(IDW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int            id;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t sb[$];
  int   acc_ids[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [BITS-1:0] d, input logic [WBITS-1:0] w);
    bus.req_data[i*BITS +: BITS]    = d;
    bus.req_weight[i*WBITS +: WBITS] = w;
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic signed [BITS-1:0] d,
                                              input logic signed [WBITS-1:0] w);
    longint p;
    p = longint'(d) * longint'(w);
    return p[PW-1:0];
  endfunction

  // Scoreboard: everything sampled at the falling edge describes the next rising edge
  exp_t                    mon_e;
  logic signed [BITS-1:0]  mon_d;
  logic signed [WBITS-1:0] mon_w;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    end else begin
      chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("sb_res_id", 64'(bus.res_id), 64'(mon_e.id));
          chk("sb_res_data", 64'(bus.res_data), 64'(mon_e.prod));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_d   = bus.req_data[i*BITS +: BITS];
          mon_w   = bus.req_weight[i*WBITS +: WBITS];
          mon_e.id   = i;
          mon_e.prod = ref_prod(mon_d, mon_w);
          sb.push_back(mon_e);
          acc_ids.push_back(i);
        end
      end
    end
  end

  initial begin
    logic [IDW-1:0] hid;
    logic [PW-1:0]  hdata;
    int             exp_id;

    reset          = 1'b1;
    bus.res_ready  = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_data   = '0;
    bus.req_weight = '0;

    // Reset state, with every requester asking
    step();
    step();
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_res_id", 64'(bus.res_id), 64'(0));
    chk("rst_res_data", 64'(bus.res_data), 64'(0));
    chk("rst_ready_comb", 64'(bus.req_ready), 64'(0));
    bus.req_valid = '0;
    reset = 1'b0;
    step();
    chk("rst_busy", 64'(bus.busy), 64'(0));

    // Single transfer 5 * -5, two-cycle latency
    set_op(0, 17'sd5, -17'sd5);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
    step();
    bus.req_valid = '0;
    chk("t1_lat1_valid", 64'(bus.res_valid), 64'(0));
    chk("t1_busy", 64'(bus.busy), 64'(1));
    step();
    chk("t1_res_valid", 64'(bus.res_valid), 64'(1));
    chk("t1_res_id", 64'(bus.res_id), 64'(0));
    chk("t1_res_data", 64'(bus.res_data), 64'(34'h3_FFFF_FFE7));
    step();
    chk("t1_drained", 64'(bus.res_valid), 64'(0));

    // Most-negative operands: product is +2^32
    set_op(0, 17'h10000, 17'h10000);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    chk("neg_res_valid", 64'(bus.res_valid), 64'(1));
    chk("neg_res_data", 64'(bus.res_data), 64'(34'h1_0000_0000));
    step();

    // Burst: all four requesters for 8 cycles after a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 17'(i * 1000 + 7), 17'(-(i * 3 + 11)));
    acc_ids.delete();
    bus.req_valid = 4'hF;
    repeat (8) step();
    bus.req_valid = '0;
    chk("burst_count", 64'(acc_ids.size()), 64'(8));
    for (int k = 0; k < 8; k++) begin
`ifdef MSA_ROUND_ROBIN_EN
      exp_id = k % NREQ;
`else
      exp_id = 0;
`endif
      if (k < acc_ids.size()) chk($sformatf("burst_grant%0d", k), 64'(acc_ids[k]), 64'(exp_id));
    end
    repeat (3) step();
    chk("burst_sb_empty", 64'(sb.size()), 64'(0));
    chk("burst_idle", 64'(bus.res_valid), 64'(0));

    // Back-pressure: consumer stalls three cycles mid-traffic
    for (int i = 0; i < NREQ; i++) set_op(i, 17'(-(i * 777 + 3)), 17'(i * 50 + 9));
    bus.req_valid = 4'hF;
    repeat (3) step();
    bus.res_ready = 1'b0;
    #1;
    chk("stall_res_valid", 64'(bus.res_valid), 64'(1));
    chk("stall_ready0", 64'(bus.req_ready), 64'(0));
    hid   = bus.res_id;
    hdata = bus.res_data;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall_ready%0d", c + 1), 64'(bus.req_ready), 64'(0));
      chk($sformatf("stall_hold_id%0d", c), 64'(bus.res_id), 64'(hid));
      chk($sformatf("stall_hold_data%0d", c), 64'(bus.res_data), 64'(hdata));
    end
    bus.res_ready = 1'b1;
    repeat (4) step();
    bus.req_valid = '0;
    repeat (3) step();
    chk("stall_sb_empty", 64'(sb.size()), 64'(0));
    chk("stall_idle", 64'(bus.res_valid), 64'(0));
    chk("stall_busy", 64'(bus.busy), 64'(0));

    // Reset one cycle after a transfer discards it
    set_op(0, 17'h10000, 17'h0FFFF);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    reset = 1'b1;
    step();
    chk("abort_res_valid", 64'(bus.res_valid), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("abort_quiet%0d", c), 64'(bus.res_valid), 64'(0));
    end
    bus.req_valid = 4'hF;
    #1;
    chk("abort_ptr_zero", 64'(bus.req_ready), 64'(4'b0001));
    step();
    bus.req_valid = '0;
    repeat (3) step();
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
